// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b controller: LSB-first full-subtract cell with operand/result shift registers and start/busy/done handshake.
// Optional zero-result flag enabled by defining SERIAL_SUB_ZERO_FLAG_EN.
module serial_sub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;

  logic x_bit, y_bit, d_bit, b_next;
  logic accept;

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic any_one_q, any_one_d;
  logic zero_q, zero_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      any_one_q <= 1'b0;
      zero_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      any_one_q <= any_one_d;
      zero_q    <= zero_d;
`endif
    end
  end

  // Full-subtract cell built from two half subtractors.
  always_comb begin
    x_bit  = a_sh_q[0];
    y_bit  = b_sh_q[0];
    d_bit  = x_bit ^ y_bit ^ brw_q;
    b_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & brw_q);
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    accept  = 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    any_one_d = any_one_q;
    zero_d    = zero_q;
`endif

    case (state_q)
      IDLE:  accept = start;
      SHIFT: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        r_sh_d = {d_bit, r_sh_q[WIDTH-1:1]};
        brw_d  = b_next;
        cnt_d  = cnt_q + CNT_W'(1);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        any_one_d = any_one_q | d_bit;
`endif
        // Results are published only on the last bit so diff never shows partial sums.
        if (cnt_q >= CNT_W'(WIDTH - 1)) begin
          diff_d  = {d_bit, r_sh_q[WIDTH-1:1]};
          bout_d  = b_next;
          state_d = DONE;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
          zero_d = ~(any_one_q | d_bit);
`endif
        end
      end
      DONE: begin
        accept  = start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      r_sh_d  = '0;
      brw_d   = 1'b0;
      cnt_d   = '0;
      state_d = SHIFT;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      any_one_d = 1'b0;
`endif
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  assign zero       = zero_q;
`endif

endmodule
